// File: rtl/aes_spi_pkg.sv
// Shared types and frame-length arithmetic for the AES job SPI master.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        WAIT,
        RX,
        DONE
    } state_e;

    localparam int unsigned BLOCK_W = 128;

    // SCLK periods in one job frame: block + key out, turnaround, block back
    function automatic int unsigned frame_bits(input int unsigned nk, input int unsigned wait_bits);
        return BLOCK_W + nk * 32 + wait_bits + BLOCK_W;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: toggles sclk every DIV clk cycles while enabled and flags
// the clk cycle in which each rising or falling SCLK edge is registered.
module spi_sclk_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick_c,
    output logic fall_tick_c
);

    localparam int unsigned DIV_W = $clog2(DIV) + 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;
    logic             tick_c;

    // Disabled generator parks low with a cleared divider so a frame starts aligned
    always_comb begin
        div_cnt_d = '0;
        sclk_d    = 1'b0;
        tick_c    = en && (div_cnt_q == DIV_W'(DIV - 1));
        if (en) begin
            div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
            sclk_d    = tick_c ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk        = sclk_q;
    assign rise_tick_c = tick_c && !sclk_q;
    assign fall_tick_c = tick_c && sclk_q;

endmodule

// File: rtl/aes_spi_master.sv
// SPI mode-0 master that ships one AES block + key to a selected engine and
// shifts the 128-bit result back, with a start/busy/done host handshake.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter  int unsigned NK        = 4,
    parameter  int unsigned NUM_CS    = 2,
    parameter  int unsigned DIV       = 2,
    parameter  int unsigned WAIT_BITS = 3,
    localparam int unsigned CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CS_W-1:0]      sel,
    input  logic [BLOCK_W-1:0]   data_in,
    input  logic [NK*32-1:0]     key,
    output logic                 busy,
    output logic                 done,
    output logic [BLOCK_W-1:0]   data_out,
    output logic                 sclk,
    output logic [NUM_CS-1:0]    cs_n,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int unsigned KEY_W    = NK * 32;
    localparam int unsigned TX_BITS  = BLOCK_W + KEY_W;
    localparam int unsigned RX_START = TX_BITS + WAIT_BITS;
    localparam int unsigned T        = frame_bits(NK, WAIT_BITS);
    localparam int unsigned CNT_W    = $clog2(T + 1);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_spi_master: NK must be 4, 6 or 8");
    end
    if (DIV < 1) begin : g_bad_div
        $error("aes_spi_master: DIV must be at least 1");
    end
    if (NUM_CS < 1) begin : g_bad_cs
        $error("aes_spi_master: NUM_CS must be at least 1");
    end

    state_e              state_q, state_d;
    logic [TX_BITS-1:0]  tx_q, tx_d;
    logic [BLOCK_W-1:0]  rx_q, rx_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BLOCK_W-1:0]  data_out_q, data_out_d;

    logic                sclk_en_c;
    logic                rise_tick_c;
    logic                fall_tick_c;
    logic                sel_ok_c;

    assign sclk_en_c = (state_q == TX) || (state_q == WAIT) || (state_q == RX);
    assign sel_ok_c  = (32'(sel) < NUM_CS);

    spi_sclk_gen #(
        .DIV (DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (sclk_en_c),
        .sclk        (sclk),
        .rise_tick_c (rise_tick_c),
        .fall_tick_c (fall_tick_c)
    );

    // Phase changes happen on SCLK falling edges; bit_cnt counts completed periods
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        cs_n_d     = cs_n_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;

        case (state_q)
            IDLE: begin
                if (start && sel_ok_c) begin
                    state_d   = TX;
                    tx_d      = {data_in, key};
                    rx_d      = '0;
                    bit_cnt_d = '0;
                    for (int unsigned i = 0; i < NUM_CS; i++) begin
                        cs_n_d[i] = (sel != CS_W'(i));
                    end
                end
            end
            TX, WAIT, RX: begin
                if (rise_tick_c && (state_q == RX)) begin
                    rx_d = {rx_q[BLOCK_W-2:0], miso};
                end
                if (fall_tick_c) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (state_q == TX) begin
                        tx_d = tx_q << 1;
                    end
                    if (bit_cnt_d == CNT_W'(T)) begin
                        state_d    = DONE;
                        cs_n_d     = '1;
                        done_d     = 1'b1;
                        data_out_d = rx_q;
                    end else if (bit_cnt_d == CNT_W'(RX_START)) begin
                        state_d = RX;
                    end else if (bit_cnt_d == CNT_W'(TX_BITS)) begin
                        state_d = WAIT;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                rx_d      = '0;
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = '1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            cs_n_q     <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    // The TX shifter drains to zero, so mosi is 0 through WAIT, RX and DONE
    assign mosi     = tx_q[TX_BITS-1];
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: two configurations driven against SPI slave models,
// expected results queued at job start and compared at done.
module tb_aes_spi_master;

    localparam int A_TX  = 256;
    localparam int B_TX  = 384;
    localparam int WB    = 3;
    localparam int A_LAT = 1549;
    localparam int B_LAT = 1031;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst;

    logic         a_start, a_busy, a_done, a_sclk, a_mosi;
    logic         a_miso = 1'b0;
    logic [0:0]   a_sel;
    logic [127:0] a_data, a_key, a_dout;
    logic [1:0]   a_cs_n;

    logic         b_start, b_busy, b_done, b_sclk, b_mosi;
    logic         b_miso = 1'b0;
    logic [1:0]   b_sel;
    logic [127:0] b_data, b_dout;
    logic [255:0] b_key;
    logic [2:0]   b_cs_n;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    aes_spi_master #(.NK(4), .NUM_CS(2), .DIV(2), .WAIT_BITS(3)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .sel(a_sel), .data_in(a_data), .key(a_key),
        .busy(a_busy), .done(a_done), .data_out(a_dout), .sclk(a_sclk), .cs_n(a_cs_n),
        .mosi(a_mosi), .miso(a_miso)
    );

    aes_spi_master #(.NK(8), .NUM_CS(3), .DIV(1), .WAIT_BITS(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .sel(b_sel), .data_in(b_data), .key(b_key),
        .busy(b_busy), .done(b_done), .data_out(b_dout), .sclk(b_sclk), .cs_n(b_cs_n),
        .mosi(b_mosi), .miso(b_miso)
    );

    // Slave A: captures mosi on SCLK rise, drives the response after SCLK falls
    logic [127:0]    a_resp;
    logic [A_TX-1:0] a_cap = '0;
    logic            a_wait_or = 1'b0, a_sclk_prev = 1'b0, a_mosi_prev = 1'b0, a_idle_prev = 1'b1;
    int              a_rise = 0, a_fall = 0, a_mosi_bad = 0;

    always @(negedge clk) begin
        a_sclk_prev <= a_sclk;
        a_mosi_prev <= a_mosi;
        a_idle_prev <= &a_cs_n;
        if (&a_cs_n) begin
            a_miso <= 1'b0;
        end else if (a_idle_prev) begin
            a_rise <= 0; a_fall <= 0; a_wait_or <= 1'b0; a_mosi_bad <= 0;
        end else begin
            if (a_sclk && !a_sclk_prev) begin
                if (a_mosi !== a_mosi_prev) a_mosi_bad <= a_mosi_bad + 1;
                if (a_rise < A_TX) a_cap <= {a_cap[A_TX-2:0], a_mosi};
                else if (a_rise < A_TX + WB) a_wait_or <= a_wait_or | a_mosi;
                a_rise <= a_rise + 1;
            end
            if (!a_sclk && a_sclk_prev) begin
                a_fall <= a_fall + 1;
                if (a_fall + 1 >= A_TX + WB && a_fall + 1 < A_TX + WB + 128)
                    a_miso <= a_resp[7'(127 - (a_fall + 1 - A_TX - WB))];
                else
                    a_miso <= 1'b0;
            end
        end
    end

    // Slave B: same protocol, 256-bit key
    logic [127:0]    b_resp;
    logic [B_TX-1:0] b_cap = '0;
    logic            b_wait_or = 1'b0, b_sclk_prev = 1'b0, b_mosi_prev = 1'b0, b_idle_prev = 1'b1;
    int              b_rise = 0, b_fall = 0, b_mosi_bad = 0;

    always @(negedge clk) begin
        b_sclk_prev <= b_sclk;
        b_mosi_prev <= b_mosi;
        b_idle_prev <= &b_cs_n;
        if (&b_cs_n) begin
            b_miso <= 1'b0;
        end else if (b_idle_prev) begin
            b_rise <= 0; b_fall <= 0; b_wait_or <= 1'b0; b_mosi_bad <= 0;
        end else begin
            if (b_sclk && !b_sclk_prev) begin
                if (b_mosi !== b_mosi_prev) b_mosi_bad <= b_mosi_bad + 1;
                if (b_rise < B_TX) b_cap <= {b_cap[B_TX-2:0], b_mosi};
                else if (b_rise < B_TX + WB) b_wait_or <= b_wait_or | b_mosi;
                b_rise <= b_rise + 1;
            end
            if (!b_sclk && b_sclk_prev) begin
                b_fall <= b_fall + 1;
                if (b_fall + 1 >= B_TX + WB && b_fall + 1 < B_TX + WB + 128)
                    b_miso <= b_resp[7'(127 - (b_fall + 1 - B_TX - WB))];
                else
                    b_miso <= 1'b0;
            end
        end
    end

    task automatic start_a(input logic [0:0] s, input logic [127:0] d, input logic [127:0] k);
        a_sel = s; a_data = d; a_key = k; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic start_b(input logic [1:0] s, input logic [127:0] d, input logic [255:0] k);
        b_sel = s; b_data = d; b_key = k; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    // Called at cycle S+1; returns at the done cycle with its offset from S
    task automatic wait_done_a(input logic [1:0] exp_cs, input int pulse_at,
                               output int lat, output bit frame_ok);
        lat = 1; frame_ok = 1'b1;
        while (a_done !== 1'b1 && lat < 4000) begin
            if (a_cs_n !== exp_cs || a_busy !== 1'b1) frame_ok = 1'b0;
            if (lat == pulse_at) begin a_start = 1'b1; a_sel = ~a_sel; a_data = ~a_data; end
            else a_start = 1'b0;
            @(negedge clk);
            lat++;
        end
        a_start = 1'b0;
        if (a_cs_n !== 2'b11 || a_sclk !== 1'b0 || a_mosi !== 1'b0) frame_ok = 1'b0;
    endtask

    task automatic wait_done_b(input logic [2:0] exp_cs, output int lat, output bit frame_ok);
        lat = 1; frame_ok = 1'b1;
        while (b_done !== 1'b1 && lat < 4000) begin
            if (b_cs_n !== exp_cs || b_busy !== 1'b1) frame_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (b_cs_n !== 3'b111 || b_sclk !== 1'b0 || b_mosi !== 1'b0) frame_ok = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({a_busy, a_done, a_sclk, a_mosi} !== 4'b0000 || a_cs_n !== 2'b11) begin
            n_fail++; $display("FAIL reset_ctrl: busy/done/sclk/mosi=%b cs_n=%b, want 0000 11",
                               {a_busy, a_done, a_sclk, a_mosi}, a_cs_n);
        end
        n_tests++;
        if (a_dout !== 128'h0) begin
            n_fail++; $display("FAIL reset_data_out: got %h want 0", a_dout);
        end
        n_tests++;
        if ({b_busy, b_done, b_sclk, b_mosi} !== 4'b0000 || b_cs_n !== 3'b111 || b_dout !== 128'h0) begin
            n_fail++; $display("FAIL reset_b: ctrl=%b cs_n=%b dout=%h", {b_busy, b_done, b_sclk, b_mosi}, b_cs_n, b_dout);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (a_busy !== 1'b0 || a_cs_n !== 2'b11) begin
            n_fail++; $display("FAIL reset_release_idle: busy=%b cs_n=%b want 0 11", a_busy, a_cs_n);
        end
    endtask

    task automatic test_fips_cipher();
        int lat; bit ok; logic [127:0] exp;
        a_resp = CT128;
        exp_q.push_back(CT128);
        start_a(1'b0, PT, K128);
        wait_done_a(2'b10, 0, lat, ok);
        exp = exp_q.pop_front();
        n_tests++;
        if (lat != A_LAT) begin n_fail++; $display("FAIL fips_latency: got %0d want %0d", lat, A_LAT); end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL fips_frame_cs: cs_n/busy wrong during frame (got 0 want 1)"); end
        n_tests++;
        if (a_dout !== exp) begin n_fail++; $display("FAIL fips_data_out: got %h want %h", a_dout, exp); end
        n_tests++;
        if (a_cap !== {PT, K128}) begin n_fail++; $display("FAIL fips_mosi_bits: got %h want %h", a_cap, {PT, K128}); end
        n_tests++;
        if (a_wait_or !== 1'b0) begin n_fail++; $display("FAIL fips_wait_bits: got %b want 0", a_wait_or); end
        n_tests++;
        if (a_mosi_bad != 0) begin n_fail++; $display("FAIL fips_mosi_stable: %0d changes at rise, want 0", a_mosi_bad); end
        @(negedge clk);
        n_tests++;
        if (a_done !== 1'b0 || a_busy !== 1'b0 || a_dout !== exp) begin
            n_fail++; $display("FAIL fips_done_pulse: done=%b busy=%b dout=%h want 0 0 %h", a_done, a_busy, a_dout, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit ok; logic [127:0] exp;
        a_resp = CT128;
        exp_q.push_back(CT128);
        start_a(1'b0, PT, K128);
        wait_done_a(2'b10, 10, lat, ok);
        exp = exp_q.pop_front();
        n_tests++;
        if (lat != A_LAT || !ok) begin n_fail++; $display("FAIL b2b_first_frame: lat=%0d ok=%0d want %0d 1", lat, ok, A_LAT); end
        n_tests++;
        if (a_dout !== exp) begin n_fail++; $display("FAIL b2b_midjob_start: got %h want %h", a_dout, exp); end
        a_start = 1'b1; a_sel = 1'b0;
        @(negedge clk);
        a_start = 1'b0;
        n_tests++;
        if (a_busy !== 1'b0 || a_cs_n !== 2'b11) begin
            n_fail++; $display("FAIL b2b_done_start: busy=%b cs_n=%b want 0 11", a_busy, a_cs_n);
        end
        // inverse-cipher engine, started in the cycle right after DONE
        a_resp = PT;
        exp_q.push_back(PT);
        start_a(1'b1, CT128, K128);
        n_tests++;
        if (a_busy !== 1'b1 || a_cs_n !== 2'b01 || a_mosi !== CT128[127]) begin
            n_fail++; $display("FAIL b2b_next_start: busy=%b cs_n=%b mosi=%b want 1 01 %b", a_busy, a_cs_n, a_mosi, CT128[127]);
        end
        wait_done_a(2'b01, 0, lat, ok);
        exp = exp_q.pop_front();
        n_tests++;
        if (lat != A_LAT || !ok) begin n_fail++; $display("FAIL b2b_sel1_frame: lat=%0d ok=%0d want %0d 1", lat, ok, A_LAT); end
        n_tests++;
        if (a_dout !== exp) begin n_fail++; $display("FAIL b2b_sel1_data: got %h want %h", a_dout, exp); end
        n_tests++;
        if (a_cap !== {CT128, K128}) begin n_fail++; $display("FAIL b2b_sel1_mosi: got %h want %h", a_cap, {CT128, K128}); end
        @(negedge clk);
    endtask

    task automatic test_invalid_sel();
        bit bad = 1'b0;
        start_b(2'd3, PT, K256);
        repeat (20) begin
            if (b_busy !== 1'b0 || b_done !== 1'b0 || b_cs_n !== 3'b111 || b_sclk !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL invalid_sel: frame activity seen (got 1 want 0)"); end
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0; int lat; bit ok; logic [127:0] exp;
        a_resp = CT128;
        start_a(1'b0, PT, K128);
        @(negedge clk);
        while (a_rise < A_TX + WB + 60 && guard < 3000) begin @(negedge clk); guard++; end
        n_tests++;
        if (a_busy !== 1'b1 || a_dout === 128'h0) begin
            n_fail++; $display("FAIL midrst_setup: busy=%b dout=%h want busy 1 and held result", a_busy, a_dout);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({a_busy, a_done, a_sclk, a_mosi} !== 4'b0000 || a_cs_n !== 2'b11) begin
            n_fail++; $display("FAIL midrst_ctrl: busy/done/sclk/mosi=%b cs_n=%b want 0000 11",
                               {a_busy, a_done, a_sclk, a_mosi}, a_cs_n);
        end
        n_tests++;
        if (a_dout !== 128'h0) begin n_fail++; $display("FAIL midrst_data_out: got %h want 0", a_dout); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(CT128);
        start_a(1'b0, PT, K128);
        wait_done_a(2'b10, 0, lat, ok);
        exp = exp_q.pop_front();
        n_tests++;
        if (lat != A_LAT || !ok || a_dout !== exp) begin
            n_fail++; $display("FAIL midrst_recover: lat=%0d ok=%0d dout=%h want %0d 1 %h", lat, ok, a_dout, A_LAT, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_nk8();
        int lat; bit ok; logic [127:0] exp;
        b_resp = PT;
        exp_q.push_back(PT);
        start_b(2'd1, CT256, K256);
        wait_done_b(3'b101, lat, ok);
        exp = exp_q.pop_front();
        n_tests++;
        if (lat != B_LAT) begin n_fail++; $display("FAIL nk8_latency: got %0d want %0d", lat, B_LAT); end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL nk8_frame_cs: cs_n/busy wrong during frame (got 0 want 1)"); end
        n_tests++;
        if (b_dout !== exp) begin n_fail++; $display("FAIL nk8_data_out: got %h want %h", b_dout, exp); end
        n_tests++;
        if (b_cap !== {CT256, K256} || b_wait_or !== 1'b0 || b_mosi_bad != 0) begin
            n_fail++; $display("FAIL nk8_mosi: cap=%h wait=%b unstable=%0d want %h 0 0", b_cap, b_wait_or, b_mosi_bad, {CT256, K256});
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_sel = '0; a_data = '0; a_key = '0; a_resp = '0;
        b_start = 1'b0; b_sel = '0; b_data = '0; b_key = '0; b_resp = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_fips_cipher();
        test_back_to_back();
        test_invalid_sel();
        test_reset_mid_frame();
        test_nk8();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
